// File: rtl/pipe_stage_reg.sv
// Generic pipeline-boundary register: DEPTH slots of {valid, payload} with stall, flush and occupancy.
// Define PIPE_STAGE_REG_STATS_EN to build the saturating stall/bubble statistics counters.
module pipe_stage_reg #(
  parameter  int DATA_W = 104,
  parameter  int DEPTH  = 1,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [OCC_W-1:0]  occ_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
);

  logic [DEPTH-1:0]  v_q, v_d;
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_d;

  // NOTE: combinational next-state uses blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = '0;
      for (int k = 0; k < DEPTH; k++) d_d[k] = '0;
    end else if (!stall_i) begin
      v_d[0] = in_valid_i;
      // A bubble always carries an all-zero payload, so its downstream control fields are inert.
      d_d[0] = in_valid_i ? in_data_i : '0;
      for (int k = 1; k < DEPTH; k++) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
  end

  // Occupancy is counted from the next-state valid bits so it lands on the same edge as the slots.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) occ_d = occ_d + OCC_W'(v_d[k]);
  end

  // NOTE: payload slots are reset too (unlike a RAM) because a cleared slot must read as an all-zero bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
    end
  end

  assign out_valid_o = v_q[DEPTH-1];
  assign out_data_o  = d_q[DEPTH-1];
  assign occ_o       = occ_q;

`ifdef PIPE_STAGE_REG_STATS_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Both counters saturate; flush leaves them alone, only reset clears them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_i && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!v_q[DEPTH-1] && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (DEPTH 1, 2, 3) share one stimulus stream.
// Counter expectations follow PIPE_STAGE_REG_STATS_EN; without it the counters must read 0.
module tb_pipe_stage_reg;

  localparam int DATA_W = 104;
`ifdef PIPE_STAGE_REG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              flush;

  logic              v1, v2, v3;
  logic [DATA_W-1:0] d1, d2, d3;
  logic              occ1;
  logic [1:0]        occ2, occ3;
  logic [31:0]       sc1, sc2, sc3, bc1, bc2, bc3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .DEPTH(1)) dut_d1 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_data_i(in_data),
    .stall_i(stall), .flush_i(flush), .out_valid_o(v1), .out_data_o(d1),
    .occ_o(occ1), .stall_cnt_o(sc1), .bubble_cnt_o(bc1));

  pipe_stage_reg #(.DATA_W(DATA_W), .DEPTH(2)) dut_d2 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_data_i(in_data),
    .stall_i(stall), .flush_i(flush), .out_valid_o(v2), .out_data_o(d2),
    .occ_o(occ2), .stall_cnt_o(sc2), .bubble_cnt_o(bc2));

  pipe_stage_reg #(.DATA_W(DATA_W), .DEPTH(3)) dut_d3 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_data_i(in_data),
    .stall_i(stall), .flush_i(flush), .out_valid_o(v3), .out_data_o(d3),
    .occ_o(occ3), .stall_cnt_o(sc3), .bubble_cnt_o(bc3));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [DATA_W-1:0] dat,
                       input logic stl, input logic fls);
    in_valid = vld;
    in_data  = dat;
    stall    = stl;
    flush    = fls;
  endtask

  task automatic reset_pulse();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
  endtask

  logic [DATA_W-1:0] ones;

  initial begin
    ones  = '1;
    rst_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    check("rst_v3",   128'(v3),   128'(0));
    check("rst_d3",   128'(d3),   128'(0));
    check("rst_occ3", 128'(occ3), 128'(0));
    check("rst_sc2",  128'(sc2),  128'(0));
    check("rst_bc1",  128'(bc1),  128'(0));
    rst_i = 1'b1;

    // Passthrough through three slots: value i emerges after edge i+2.
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
      else        drive(1'b0, DATA_W'('h55), 1'b0, 1'b0);
      step();
      check($sformatf("pass_v3_%0d", i),   128'(v3), 128'(i >= 3));
      check($sformatf("pass_d3_%0d", i),   128'(d3), (i >= 3) ? 128'(i - 2) : 128'(0));
      check($sformatf("pass_occ3_%0d", i), 128'(occ3),
            (i <= 3) ? 128'(i) : 128'(6 - i + 1 - ((i == 4) ? 0 : 0)));
    end

    // Fill all three slots, then reset asynchronously between edges.
    for (int i = 7; i <= 9; i++) begin
      drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
      step();
    end
    check("mid_occ3_pre", 128'(occ3), 128'(3));
    check("mid_d3_pre",   128'(d3),   128'(7));
    rst_i = 1'b0;
    #2;
    check("mid_v3",   128'(v3),   128'(0));
    check("mid_d3",   128'(d3),   128'(0));
    check("mid_occ3", 128'(occ3), 128'(0));
    check("mid_occ2", 128'(occ2), 128'(0));
    step();
    rst_i = 1'b1;

    // Stall on DEPTH=2: 0xA must be held while 0xC is presented and dropped.
    drive(1'b1, DATA_W'('hA), 1'b0, 1'b0); step();
    drive(1'b1, DATA_W'('hB), 1'b0, 1'b0); step();
    check("stl_d2_load",  128'(d2),   128'('hA));
    check("stl_occ2_load", 128'(occ2), 128'(2));
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, DATA_W'('hC), 1'b1, 1'b0);
      step();
      check($sformatf("stl_v2_%0d", i),   128'(v2),   128'(1));
      check($sformatf("stl_d2_%0d", i),   128'(d2),   128'('hA));
      check($sformatf("stl_occ2_%0d", i), 128'(occ2), 128'(2));
    end
    check("stl_sc2", 128'(sc2), STATS ? 128'(2) : 128'(0));
    check("stl_bc2", 128'(bc2), STATS ? 128'(2) : 128'(0));
    drive(1'b0, DATA_W'('hC), 1'b0, 1'b0); step();
    check("stl_d2_after", 128'(d2),   128'('hB));
    check("stl_occ2_after", 128'(occ2), 128'(1));
    step();
    check("stl_v2_drain", 128'(v2), 128'(0));
    check("stl_d2_drain", 128'(d2), 128'(0));

    // Flush and stall together: flush wins, stall still counted.
    drive(1'b1, DATA_W'('h11), 1'b0, 1'b0); step();
    drive(1'b1, DATA_W'('h22), 1'b0, 1'b0); step();
    check("fl_occ2_pre", 128'(occ2), 128'(2));
    check("fl_d2_pre",   128'(d2),   128'('h11));
    drive(1'b1, DATA_W'('h33), 1'b1, 1'b1); step();
    check("fl_v2",   128'(v2),   128'(0));
    check("fl_d2",   128'(d2),   128'(0));
    check("fl_occ2", 128'(occ2), 128'(0));
    check("fl_occ3", 128'(occ3), 128'(0));
    check("fl_sc2",  128'(sc2),  STATS ? 128'(3) : 128'(0));
    check("fl_bc2",  128'(bc2),  STATS ? 128'(4) : 128'(0));

    // DEPTH=1 as a plain register, then bubble zeroing with all-ones payload.
    drive(1'b0, '0, 1'b0, 1'b0);
    reset_pulse();
    drive(1'b1, ones, 1'b0, 1'b0); step();
    check("bz_v1_valid", 128'(v1),   128'(1));
    check("bz_d1_valid", 128'(d1),   128'(ones));
    check("bz_occ1",     128'(occ1), 128'(1));
    drive(1'b0, ones, 1'b0, 1'b0); step();
    check("bz_v1", 128'(v1), 128'(0));
    check("bz_d1", 128'(d1), 128'(0));
    step();
    check("bz_bc1_a", 128'(bc1), STATS ? 128'(2) : 128'(0));
    step();
    check("bz_bc1_b", 128'(bc1), STATS ? 128'(3) : 128'(0));
    check("bz_d1_b",  128'(d1),  128'(0));

`ifdef PIPE_STAGE_REG_STATS_EN
    // Preload the bubble counter just below the ceiling, then confirm it pins at all-ones.
    force dut_d1.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut_d1.bubble_cnt_q;
    step();
    check("sat_bc1_a", 128'(bc1), 128'(32'hFFFF_FFFF));
    step();
    check("sat_bc1_b", 128'(bc1), 128'(32'hFFFF_FFFF));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-boundary register that replaces the per-stage fixed-field registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Carries an opaque payload of configurable width through DEPTH back-to-back slots, each with its own valid bit. Adds stall (hold), flush (bubble insertion) and occupancy reporting, plus optional stall/bubble statistics counters. Hazard-detection logic drives stall/flush; the payload is packed and unpacked by the surrounding stage logic.

## Interface
- DATA_W, 104, payload width in bits (default covers WB ctrl 3 + DM 32 + ALU 32 + reg 5 + PC+4 32)
- DEPTH, 1, number of register slots in series; legal range 1..8
- OCC_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

- clk_i  input  1  clock, rising-edge
- rst_i  input  1  asynchronous, active-low reset
- in_valid_i  input  1  payload on in_data_i is a real instruction
- in_data_i  input  DATA_W  incoming payload
- stall_i  input  1  hold all slots this cycle
- flush_i  input  1  clear all slots to bubbles this cycle
- out_valid_o  output  1  valid bit of last slot
- out_data_o  output  DATA_W  payload of last slot
- occ_o  output  OCC_W  number of valid slots
- stall_cnt_o  output  32  stall cycles seen (PIPE_STAGE_REG_STATS_EN only)
- bubble_cnt_o  output  32  cycles with out_valid_o=0 (PIPE_STAGE_REG_STATS_EN only)

## Operation
- Slots s[0]..s[DEPTH-1]; each holds valid bit v[k] and data d[k]; s[DEPTH-1] drives out_valid_o/out_data_o.
- Per rising edge, priority flush_i > stall_i > advance:
  - flush_i=1: every v[k]<=0, every d[k]<=0, regardless of stall_i or in_valid_i.
  - stall_i=1 (flush_i=0): all slots hold; in_data_i dropped (upstream must hold too).
  - otherwise advance: s[0]<=input, s[k]<=s[k-1] for k>=1.
- Bubble zeroing: when loading s[0] with in_valid_i=0, d[0]<=0 irrespective of in_data_i, so downstream control fields (e.g. reg-write enable) of a bubble are always 0.
- Invariant: v[k]=0 implies d[k]=0 in every cycle.
- occ_o = popcount(v[0..DEPTH-1]), registered alongside the slots (updated same edge, no combinational popcount on output path required but allowed).
- No back-pressure output; block never refuses data except under stall_i.

## Timing
- Reset (rst_i=0, asynchronous assert): all v[k]=0, d[k]=0, out_valid_o=0, out_data_o=0, occ_o=0, stall_cnt_o=0, bubble_cnt_o=0. Deassertion is synchronised externally; first capture on first rising edge with rst_i=1.
- Latency: input captured at edge N appears on outputs after edge N+DEPTH-1 (i.e. DEPTH edges from presentation), plus one extra edge per stall cycle in between.
- DEPTH=1 with stall_i=flush_i=0 is cycle-identical to a plain pipeline register with zeroing reset.
- Flush and stall same cycle: flush wins; stall counter still increments.
- Reset mid-operation: immediate clear, all in-flight payloads lost, counters cleared.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- PIPE_STAGE_REG_STATS_EN defined: stall_cnt_o increments on every edge with stall_i=1; bubble_cnt_o increments on every edge where out_valid_o (pre-edge value) is 0; both saturate at 32'hFFFF_FFFF; flush_i does not clear them, only rst_i.
- Not defined: stall_cnt_o and bubble_cnt_o are still present as ports but tied to 0; no counter flops synthesised.

## Test plan
- Reset: drive rst_i=0 mid-stream with DEPTH=3 and 3 valid slots -> all outputs 0 immediately (before next edge), occ_o=0.
- Passthrough DEPTH=3: in_valid_i=1, data 1,2,3,4 on consecutive edges -> out_data_o=1 after 3rd edge, then 2,3,4; occ_o reaches 3.
- Stall: DEPTH=2, load 0xA, 0xB, assert stall_i 2 cycles with in_data_i=0xC -> outputs hold 0xA, 0xC never captured during stall; stall_cnt_o=2 (stats build).
- Flush priority: flush_i=1 and stall_i=1 with occ_o=2 -> next edge out_valid_o=0, out_data_o=0, occ_o=0.
- Bubble zeroing: in_valid_i=0, in_data_i=all ones, DEPTH=1 -> out_data_o=0, out_valid_o=0; bubble_cnt_o increments each such output cycle.
- Saturation (stats build): force bubble_cnt_o to 32'hFFFF_FFFE via long idle/backdoor, two more bubble edges -> stays 32'hFFFF_FFFF.
